// File: rtl/ifetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_stage_if
// Brief    : Instruction SRAM req/ready bus between the fetch stage and SRAM.
// Revision : 1.0 - initial release
// ============================================================================
interface ifetch_stage_if #(
    parameter int PC_DATA_WIDTH     = 20,
    parameter int INSTRUCTION_WIDTH = 32
);
    logic                         inst_mem_req_out;
    logic [PC_DATA_WIDTH-1:0]     inst_mem_addr_out;
    logic                         inst_mem_ready_in;
    logic [INSTRUCTION_WIDTH-1:0] inst_mem_data_in;

    // Fetch stage drives the request side.
    modport master (
        output inst_mem_req_out,
        output inst_mem_addr_out,
        input  inst_mem_ready_in,
        input  inst_mem_data_in
    );

    // SRAM answers with a same-cycle ready strobe and data.
    modport slave (
        input  inst_mem_req_out,
        input  inst_mem_addr_out,
        output inst_mem_ready_in,
        output inst_mem_data_in
    );
endinterface
`default_nettype wire

// File: rtl/ifetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_stage
// Brief    : PC owner and instruction SRAM fetcher with one-entry skid buffer
//            and redirect handling. Optional macro IFETCH_PERF_CNT_EN adds a
//            saturating count of SRAM wait cycles.
// Revision : 1.0 - initial release
// ============================================================================
module ifetch_stage #(
    parameter int                       PC_DATA_WIDTH     = 20,
    parameter int                       INSTRUCTION_WIDTH = 32,
    parameter logic [PC_DATA_WIDTH-1:0] RESET_PC          = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall,
    input  logic                         branch_taken,
    input  logic [PC_DATA_WIDTH-1:0]     branch_target,
    ifetch_stage_if.master               mem,
    output logic [INSTRUCTION_WIDTH-1:0] instruction_out,
    output logic [PC_DATA_WIDTH-1:0]     pc_out,
    output logic                         valid_out,
    output logic                         mem_wait_out
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0]                  fetch_wait_cycles_out
`endif
);

    localparam logic [PC_DATA_WIDTH-1:0] c_pc_step = PC_DATA_WIDTH'(4);

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_HOLD    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t                       r_state;
    state_t                       w_state_nxt;
    logic [PC_DATA_WIDTH-1:0]     r_pc;
    logic [PC_DATA_WIDTH-1:0]     w_pc_nxt;
    logic [PC_DATA_WIDTH-1:0]     r_redirect_pc;
    logic [PC_DATA_WIDTH-1:0]     w_redirect_nxt;
    logic [INSTRUCTION_WIDTH-1:0] r_skid_inst;
    logic [INSTRUCTION_WIDTH-1:0] w_skid_inst_nxt;
    logic [PC_DATA_WIDTH-1:0]     r_skid_pc;
    logic [PC_DATA_WIDTH-1:0]     w_skid_pc_nxt;
    logic [INSTRUCTION_WIDTH-1:0] r_inst;
    logic [INSTRUCTION_WIDTH-1:0] w_inst_nxt;
    logic [PC_DATA_WIDTH-1:0]     r_pc_out;
    logic [PC_DATA_WIDTH-1:0]     w_pc_out_nxt;
    logic                         r_valid;
    logic                         w_valid_nxt;

    logic                         w_req;
    logic                         w_ready;
    logic                         w_mem_wait;
    logic [PC_DATA_WIDTH-1:0]     w_pc_plus4;

    assign w_req      = (r_state != S_HOLD);
    assign w_ready    = mem.inst_mem_ready_in;
    assign w_mem_wait = w_req & ~w_ready;
    assign w_pc_plus4 = r_pc + c_pc_step;

    assign mem.inst_mem_req_out  = w_req;
    assign mem.inst_mem_addr_out = r_pc;
    assign instruction_out       = r_inst;
    assign pc_out                = r_pc_out;
    assign valid_out             = r_valid;
    assign mem_wait_out          = w_mem_wait;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_FETCH;
            r_pc          <= RESET_PC;
            r_redirect_pc <= '0;
            r_skid_inst   <= '0;
            r_skid_pc     <= '0;
            r_inst        <= '0;
            r_pc_out      <= '0;
            r_valid       <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_redirect_pc <= w_redirect_nxt;
            r_skid_inst   <= w_skid_inst_nxt;
            r_skid_pc     <= w_skid_pc_nxt;
            r_inst        <= w_inst_nxt;
            r_pc_out      <= w_pc_out_nxt;
            r_valid       <= w_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_redirect_nxt  = r_redirect_pc;
        w_skid_inst_nxt = r_skid_inst;
        w_skid_pc_nxt   = r_skid_pc;
        w_inst_nxt      = r_inst;
        w_pc_out_nxt    = r_pc_out;
        w_valid_nxt     = r_valid;

        if (branch_taken) begin
            w_inst_nxt      = '0;
            w_valid_nxt     = 1'b0;
            w_skid_inst_nxt = '0;
            w_skid_pc_nxt   = '0;
            // An access still in flight must keep its address until it
            // completes, so the redirect is parked instead of applied.
            if (w_mem_wait) begin
                w_redirect_nxt = branch_target;
                w_state_nxt    = S_DISCARD;
            end else begin
                w_pc_nxt    = branch_target;
                w_state_nxt = S_FETCH;
            end
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (w_ready) begin
                        w_pc_nxt = w_pc_plus4;
                        if (!stall) begin
                            w_inst_nxt   = mem.inst_mem_data_in;
                            w_pc_out_nxt = w_pc_plus4;
                            w_valid_nxt  = 1'b1;
                        end else begin
                            w_skid_inst_nxt = mem.inst_mem_data_in;
                            w_skid_pc_nxt   = w_pc_plus4;
                            w_state_nxt     = S_HOLD;
                        end
                    end else if (!stall) begin
                        w_inst_nxt  = '0;
                        w_valid_nxt = 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        w_inst_nxt      = r_skid_inst;
                        w_pc_out_nxt    = r_skid_pc;
                        w_valid_nxt     = 1'b1;
                        w_skid_inst_nxt = '0;
                        w_skid_pc_nxt   = '0;
                        w_state_nxt     = S_FETCH;
                    end
                end
                S_DISCARD: begin
                    if (w_ready) begin
                        w_pc_nxt    = r_redirect_pc;
                        w_state_nxt = S_FETCH;
                    end
                    if (!stall) begin
                        w_inst_nxt  = '0;
                        w_valid_nxt = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt = S_FETCH;
                end
            endcase
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] r_wait_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else if (w_mem_wait && (r_wait_cnt != 32'hFFFF_FFFF)) begin
            r_wait_cnt <= r_wait_cnt + 32'd1;
        end
    end

    assign fetch_wait_cycles_out = r_wait_cnt;
`endif

endmodule
`default_nettype wire
